// File: rtl/muldiv_unit.sv
// Purpose : execute-stage MULT/MULTU/DIV/DIVU/MTHI/MTLO unit that owns the HI/LO registers.
// Latency : MUL 2 edges after issue, DIV 32 edges after issue, MTHI/MTLO at the issue edge.
// Backpres: busy_o stalls F/D/E while an op is in flight; done_o holds while stall_i is high.
//
// Ports: clk/resetn (async active-low); valid_i/op_i/a_i/b_i issue an op from E;
//        stall_i holds done_o; flush_i kills the op in E; busy_o -> hazard unit;
//        done_o pulses (or holds under stall) after commit; hi_o/lo_o architectural HI/LO.
// Option: define MULDIV_FAST_DIV0_EN to commit divide-by-zero results at the issue edge.
module muldiv_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_MUL1, S_MUL2, S_DIV} state_t;

  state_t      state;
  logic [31:0] op_a;        // multiplicand, or raw dividend (kept for divide-by-zero HI)
  logic [31:0] op_b;        // multiplier, or divisor magnitude
  logic        mul_signed;
  logic [31:0] pp_ll, pp_lh, pp_hl, pp_hh;
  logic [31:0] pp_corr;     // high-word correction that turns the unsigned product into a signed one
  logic [31:0] rem, quo;
  logic [4:0]  cnt;
  logic        q_neg, r_neg, div0;

  logic issue, is_mul, is_div;
  assign issue  = (state == S_IDLE) && valid_i && !done_o && !flush_i;
  assign is_mul = (op_i == OP_MULT) || (op_i == OP_MULTU);
  assign is_div = (op_i == OP_DIV)  || (op_i == OP_DIVU);
  assign busy_o = (issue && (is_mul || is_div)) || (state != S_IDLE);

  // Operand magnitudes for signed divide; 0x80000000 maps to itself, which is
  // the correct unsigned magnitude.
  logic [31:0] a_mag, b_mag;
  assign a_mag = (op_i == OP_DIV && a_i[31]) ? -a_i : a_i;
  assign b_mag = (op_i == OP_DIV && b_i[31]) ? -b_i : b_i;

  logic [63:0] mul_sum;
  assign mul_sum = {pp_hh, 32'h0} + {16'h0, pp_hl, 16'h0}
                 + {16'h0, pp_lh, 16'h0} + {32'h0, pp_ll};

  // One restoring step: shift the next dividend bit into the remainder and
  // keep the subtraction only if it did not borrow.
  logic [32:0] div_shift, div_diff;
  logic [31:0] rem_nxt, quo_nxt;
  assign div_shift = {rem, quo[31]};
  assign div_diff  = div_shift - {1'b0, op_b};
  assign rem_nxt   = div_diff[32] ? div_shift[31:0] : div_diff[31:0];
  assign quo_nxt   = {quo[30:0], ~div_diff[32]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      done_o     <= 1'b0;
      hi_o       <= 32'h0;
      lo_o       <= 32'h0;
      op_a       <= 32'h0;
      op_b       <= 32'h0;
      mul_signed <= 1'b0;
      pp_ll      <= 32'h0;
      pp_lh      <= 32'h0;
      pp_hl      <= 32'h0;
      pp_hh      <= 32'h0;
      pp_corr    <= 32'h0;
      rem        <= 32'h0;
      quo        <= 32'h0;
      cnt        <= 5'd0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      div0       <= 1'b0;
    end else if (flush_i) begin
      state  <= S_IDLE;
      done_o <= 1'b0;
    end else begin
      if (done_o && !stall_i)
        done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (issue) begin
            case (op_i)
              OP_MULT, OP_MULTU: begin
                op_a       <= a_i;
                op_b       <= b_i;
                mul_signed <= (op_i == OP_MULT);
                state      <= S_MUL1;
              end
              OP_DIV, OP_DIVU: begin
`ifdef MULDIV_FAST_DIV0_EN
                if (b_i == 32'h0) begin
                  hi_o   <= a_i;
                  lo_o   <= 32'hFFFF_FFFF;
                  done_o <= 1'b1;
                end else
`endif
                begin
                  op_a  <= a_i;
                  op_b  <= b_mag;
                  rem   <= 32'h0;
                  quo   <= a_mag;
                  q_neg <= (op_i == OP_DIV) && (a_i[31] ^ b_i[31]);
                  r_neg <= (op_i == OP_DIV) && a_i[31];
                  div0  <= (b_i == 32'h0);
                  cnt   <= 5'd0;
                  state <= S_DIV;
                end
              end
              OP_MTHI: hi_o <= a_i;
              OP_MTLO: lo_o <= a_i;
              default: ;
            endcase
          end
        end
        S_MUL1: begin
          pp_ll <= {16'h0, op_a[15:0]}  * {16'h0, op_b[15:0]};
          pp_lh <= {16'h0, op_a[15:0]}  * {16'h0, op_b[31:16]};
          pp_hl <= {16'h0, op_a[31:16]} * {16'h0, op_b[15:0]};
          pp_hh <= {16'h0, op_a[31:16]} * {16'h0, op_b[31:16]};
          // Equivalent to sign-extending both operands to 33 bits: a negative
          // operand subtracts the other operand from the high word.
          pp_corr <= ((mul_signed && op_a[31]) ? op_b : 32'h0)
                   + ((mul_signed && op_b[31]) ? op_a : 32'h0);
          state <= S_MUL2;
        end
        S_MUL2: begin
          hi_o   <= mul_sum[63:32] - pp_corr;
          lo_o   <= mul_sum[31:0];
          done_o <= 1'b1;
          state  <= S_IDLE;
        end
        S_DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            if (div0) begin
              hi_o <= op_a;
              lo_o <= 32'hFFFF_FFFF;
            end else begin
              hi_o <= r_neg ? -rem_nxt : rem_nxt;
              lo_o <= q_neg ? -quo_nxt : quo_nxt;
            end
            done_o <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid_i;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        stall_i, flush_i;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  muldiv_unit dut (
    .clk(clk), .resetn(resetn), .valid_i(valid_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .stall_i(stall_i), .flush_i(flush_i),
    .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model_hl;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural reference: {HI, LO} after op commits, from plain arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    longint sa, sb;
    int     qa, qb;
    case (op)
      3'd0: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
      end
      3'd1: return {32'h0, a} * {32'h0, b};
      3'd2: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        qa = $signed(a);
        qb = $signed(b);
        return {32'(qa % qb), 32'(qa / qb)};
      end
      3'd3: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd4: return {a, cur[31:0]};
      3'd5: return {cur[63:32], a};
      default: return cur;
    endcase
  endfunction

  // Monitor: every rising done_o consumes one expected result.
  initial begin
    logic        done_q;
    logic [63:0] e;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        done_q = 1'b0;
      end else begin
        if (done_o && !done_q) begin
          check("sb_has_entry", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("result_hilo", {hi_o, lo_o}, e);
          end
        end
        done_q = done_o;
      end
    end
  end

  // Called at a negedge; presents the op in E as the hazard unit would and
  // returns at the negedge after the instruction leaves E.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall_n);
    logic [63:0] exp;
    int lat, cyc, busy_n;
    exp = model(op, a, b, model_hl);
    valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
    if (op >= 3'd4) begin
      #1;
      check("mt_busy", 64'(busy_o), 64'd0);
      @(negedge clk);
      valid_i = 1'b0;
      model_hl = exp;
      check("mt_hilo", {hi_o, lo_o}, exp);
      return;
    end
    lat = (op < 3'd2) ? 3 : 33;
`ifdef MULDIV_FAST_DIV0_EN
    if (b == 32'h0) lat = 1;
`endif
    exp_q.push_back(exp);
    busy_n = 0;
    cyc = 0;
    #1;
    while (!done_o && cyc < 200) begin
      if (busy_o) busy_n++;
      @(negedge clk);
      cyc++;
    end
    check("done_seen", 64'(cyc < 200), 64'd1);
    check("busy_cycles", 64'(busy_n), 64'(lat));
    model_hl = exp;
    for (int i = 0; i < stall_n; i++) begin
      stall_i = 1'b1;
      check("stall_done_held", 64'(done_o), 64'd1);
      check("stall_no_reissue", 64'(busy_o), 64'd0);
      check("stall_hilo_stable", {hi_o, lo_o}, exp);
      @(negedge clk);
    end
    stall_i = 1'b0;
    check("done_at_advance", 64'(done_o), 64'd1);
    check("busy_at_advance", 64'(busy_o), 64'd0);
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    check("done_clear", 64'(done_o), 64'd0);
    check("hilo_after", {hi_o, lo_o}, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        saw_done;
    logic [2:0]  op;
    logic [31:0] a, b;
    int          sel;

    resetn = 1'b0; valid_i = 1'b0; op_i = 3'd0; a_i = 32'h0; b_i = 32'h0;
    stall_i = 1'b0; flush_i = 1'b0;
    model_hl = 64'h0;
    repeat (3) @(negedge clk);
    check("reset_hilo", {hi_o, lo_o}, 64'h0);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_done", 64'(done_o), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Directed, issued back to back.
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 0);
    check("mult_m2x3", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 0);
    check("multu_m2x3", {hi_o, lo_o}, 64'h0000_0002_FFFF_FFFA);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_m7_2", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf", {hi_o, lo_o}, 64'h0000_0000_8000_0000);
    run_op(3'd3, 32'h1234_5678, 32'h0, 0);
    check("divu_by0", {hi_o, lo_o}, 64'h1234_5678_FFFF_FFFF);
    run_op(3'd2, 32'h8765_4321, 32'h0, 1);
    run_op(3'd0, 32'h0001_0003, 32'hFFFF_0005, 4);

    // Flush in the middle of a divide, after an MTLO.
    run_op(3'd5, 32'hCAFE_BABE, 32'h0, 0);
    valid_i = 1'b1; op_i = 3'd2; a_i = 32'd1000; b_i = 32'd7;
    repeat (6) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; valid_i = 1'b0;
    #1;
    check("flush_busy", 64'(busy_o), 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) saw_done = 1'b1;
    end
    check("flush_no_done", 64'(saw_done), 64'd0);
    check("flush_lo", 64'(lo_o), 64'hCAFE_BABE);
    check("flush_hilo", {hi_o, lo_o}, model_hl);
    run_op(3'd0, 32'd12345, 32'hFFFF_FF00, 0);

    // Reset during iteration 10 of a divide.
    valid_i = 1'b1; op_i = 3'd3; a_i = 32'hDEAD_BEEF; b_i = 32'd13;
    repeat (11) @(negedge clk);
    resetn = 1'b0; valid_i = 1'b0;
    #1;
    check("rst_mid_hilo", {hi_o, lo_o}, 64'h0);
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    check("rst_mid_done", 64'(done_o), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    model_hl = 64'h0;
    @(negedge clk);

    // Randomized ops with random stalls.
    for (int k = 0; k < 24; k++) begin
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      sel = $urandom_range(0, 5);
      case (sel)
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_op(op, a, b, $urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
